// File: rtl/mmio_clint_multi.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_clint_multi
//  Purpose  : Multi-hart core-local interruptor on the MMIO request bus.
//             Free-running mtime with a 1 MHz prescaler, per-hart mtimecmp
//             and msip registers, per-hart timer/software interrupt lines.
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_clint_multi #(
    parameter int              FMAX_MHz = 27,
    parameter int              HART_NUM = 1,
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h0200_0000)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                req_ready,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_wen,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [63:0]         mtime,
    output logic [HART_NUM-1:0] mtip,
    output logic [HART_NUM-1:0] msip
);

    localparam int              C_PW        = (FMAX_MHz > 1) ? $clog2(FMAX_MHz) : 1;
    localparam logic [C_PW-1:0] C_PRESC_MAX = C_PW'(FMAX_MHz - 1);
    localparam logic [63:0]     C_CMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [C_PW-1:0]     r_presc;
    logic [63:0]         r_mtime;
    logic [63:0]         r_mtimecmp [HART_NUM];
    logic [HART_NUM-1:0] r_msip;
    logic [HART_NUM-1:0] r_mtip;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;

    logic                w_accept;
    logic                w_wr;
    logic                w_tick;
    logic [ADDR_W-1:0]   w_off;
    logic [15:0]         w_off16;
    logic                w_in_win;
    logic                w_half;
    logic                w_msip_hit;
    logic                w_cmp_hit;
    logic                w_mtime_hit;
    logic [2:0]          w_msip_idx;
    logic [2:0]          w_cmp_idx;
    logic [63:0]         w_wd64;
    logic [DATA_W-1:0]   w_rd;

    // Merge bus write data into a 64-bit register; 32-bit buses touch one half only
    function automatic logic [63:0] f_merge(input logic [63:0] i_old,
                                            input logic [63:0] i_wd,
                                            input logic        i_hi);
        logic [63:0] v_new;
        if (DATA_W == 64) begin
            v_new = i_wd;
        end else if (i_hi) begin
            v_new = {i_wd[31:0], i_old[31:0]};
        end else begin
            v_new = {i_old[63:32], i_wd[31:0]};
        end
        return v_new;
    endfunction

    assign req_ready = ~reset;
    assign w_accept  = req_valid & ~reset;
    assign w_wr      = w_accept & req_wen;
    assign w_tick    = (r_presc == C_PRESC_MAX);
    assign w_wd64    = 64'(req_wdata);

    // Address decode: the CLINT window is 64 KiB above BASE, word-aligned registers
    assign w_off       = req_addr - BASE;
    assign w_off16     = w_off[15:0];
    assign w_in_win    = (w_off[ADDR_W-1:16] == '0);
    assign w_half      = (DATA_W == 32) && w_off16[2];
    assign w_msip_idx  = w_off16[4:2];
    assign w_cmp_idx   = w_off16[5:3];
    assign w_msip_hit  = w_in_win && (w_off16[15:5] == 11'd0) && (w_off16[1:0] == 2'd0)
                         && ({1'b0, w_msip_idx} < 4'(HART_NUM));
    assign w_cmp_hit   = w_in_win && (w_off16[15:6] == 10'h100) && (w_off16[1:0] == 2'd0)
                         && ({1'b0, w_cmp_idx} < 4'(HART_NUM))
                         && ((DATA_W == 32) || !w_off16[2]);
    assign w_mtime_hit = w_in_win && (w_off16[15:3] == 13'h17FF) && (w_off16[1:0] == 2'd0)
                         && ((DATA_W == 32) || !w_off16[2]);

    // Read mux over current register values (read-before-write), zero if unmapped
    always_comb begin
        w_rd = '0;
        if (w_msip_hit) begin
            for (int h = 0; h < HART_NUM; h++) begin
                if (w_msip_idx == 3'(h)) begin
                    w_rd = DATA_W'(r_msip[h]);
                end
            end
        end
        if (w_cmp_hit) begin
            for (int h = 0; h < HART_NUM; h++) begin
                if (w_cmp_idx == 3'(h)) begin
                    w_rd = w_half ? DATA_W'(r_mtimecmp[h][63:32]) : DATA_W'(r_mtimecmp[h]);
                end
            end
        end
        if (w_mtime_hit) begin
            w_rd = w_half ? DATA_W'(r_mtime[63:32]) : DATA_W'(r_mtime);
        end
    end

    // Prescaler and mtime; a software write to mtime overrides a same-cycle tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_mtime <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_wr && w_mtime_hit) begin
                r_mtime <= f_merge(r_mtime, w_wd64, w_half);
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
        end
    end

    // Per-hart compare registers, software interrupt bits and registered timer pending
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int h = 0; h < HART_NUM; h++) begin
                r_mtimecmp[h] <= C_CMP_RST;
            end
            r_msip <= '0;
            r_mtip <= '0;
        end else begin
            for (int h = 0; h < HART_NUM; h++) begin
                r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
                if (w_wr && w_cmp_hit && (w_cmp_idx == 3'(h))) begin
                    r_mtimecmp[h] <= f_merge(r_mtimecmp[h], w_wd64, w_half);
                end
                if (w_wr && w_msip_hit && (w_msip_idx == 3'(h))) begin
                    r_msip[h] <= w_wd64[0];
                end
            end
        end
    end

    // One-cycle response for every accepted request; write responses carry zero data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_accept;
            r_resp_rdata <= (w_accept && !req_wen) ? w_rd : '0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign mtime      = r_mtime;
    assign mtip       = r_mtip;
    assign msip       = r_msip;

endmodule
`default_nettype wire
